// File: rtl/rr_handshake_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_handshake_arbiter_if
// Bundle of the arbiter's handshake and data signals.
//   in_req    NUM_REQ        two-phase requests from producers (toggle = token)
//   in_ack    NUM_REQ        two-phase acknowledges back to producers
//   in_data   NUM_REQ*WIDTH  producer i data at [i*WIDTH +: WIDTH]
//   out_req   1              two-phase request to the consumer
//   out_ack   1              two-phase acknowledge from the consumer
//   out_data  WIDTH          forwarded token
//   out_src   SRC_W          index of the producer owning out_data
//   busy      1              high while a token is outstanding at the consumer
//   proto_err 1              sticky consumer protocol-error flag
// Modports: master = arbiter side, slave = producers/consumer side.
// -----------------------------------------------------------------------------
interface rr_handshake_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       in_req;
    logic [NUM_REQ-1:0]       in_ack;
    logic [NUM_REQ*WIDTH-1:0] in_data;
    logic                     out_req;
    logic                     out_ack;
    logic [WIDTH-1:0]         out_data;
    logic [SRC_W-1:0]         out_src;
    logic                     busy;
    logic                     proto_err;

    modport master (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, out_src, busy, proto_err
    );

    modport slave (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, out_src, busy, proto_err
    );
endinterface

// File: rtl/rr_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// rr_handshake_arbiter
// Round-robin arbiter sharing one two-phase bundled-data output channel between
// NUM_REQ two-phase requesters. Each grant forwards exactly one token.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_handshake_arbiter_if.master (see interface header for signals)
// Optional feature macro: ARB_SYNC_EN -- when defined, in_req and out_ack pass
// through 2-flop synchronisers before use (in_data relies on bundled-data
// stability and is captured only at grant).
// -----------------------------------------------------------------------------
module rr_handshake_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rr_handshake_arbiter_if.master   bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_r, state_next_s;
    logic [SRC_W-1:0]     rr_ptr_r, rr_ptr_next_s;
    logic [NUM_REQ-1:0]   in_ack_r, in_ack_next_s;
    logic                 out_req_r, out_req_next_s;
    logic [WIDTH-1:0]     out_data_r, out_data_next_s;
    logic [SRC_W-1:0]     out_src_r, out_src_next_s;
    logic                 busy_r, busy_next_s;
    logic                 proto_err_r, proto_err_next_s;

    logic [NUM_REQ-1:0]   in_req_s;
    logic                 out_ack_s;
    logic [NUM_REQ-1:0]   pending_s;
    logic                 any_s;
    logic [SRC_W-1:0]     sel_s;
    logic [WIDTH-1:0]     sel_data_s;
    logic [SRC_W-1:0]     ptr_inc_s;

`ifdef ARB_SYNC_EN
    logic [NUM_REQ-1:0]   in_req_meta_r, in_req_sync_r;
    logic                 out_ack_meta_r, out_ack_sync_r;

    // Two-flop synchronisers for the asynchronous handshake inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_req_meta_r  <= '0;
            in_req_sync_r  <= '0;
            out_ack_meta_r <= 1'b0;
            out_ack_sync_r <= 1'b0;
        end else begin
            in_req_meta_r  <= bus.in_req;
            in_req_sync_r  <= in_req_meta_r;
            out_ack_meta_r <= bus.out_ack;
            out_ack_sync_r <= out_ack_meta_r;
        end
    end

    assign in_req_s  = in_req_sync_r;
    assign out_ack_s = out_ack_sync_r;
`else
    assign in_req_s  = bus.in_req;
    assign out_ack_s = bus.out_ack;
`endif

    // A requester has a token outstanding while its req and ack phases differ.
    assign pending_s = in_req_s ^ in_ack_r;

    // Round-robin pick: scan downward so the smallest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx        = 0;
        any_s      = 1'b0;
        sel_s      = '0;
        sel_data_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (pending_s[idx]) begin
                any_s      = 1'b1;
                sel_s      = SRC_W'(idx);
                sel_data_s = bus.in_data[idx*WIDTH +: WIDTH];
            end else begin
                any_s      = any_s;
            end
        end
    end

    // Pointer to the requester after the one just served, wrapping to 0.
    always_comb begin
        int nxt;
        nxt = int'(out_src_r) + 1;
        if (nxt >= NUM_REQ) begin
            nxt = 0;
        end else begin
            nxt = nxt;
        end
        ptr_inc_s = SRC_W'(nxt);
    end

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        state_next_s     = state_r;
        rr_ptr_next_s    = rr_ptr_r;
        in_ack_next_s    = in_ack_r;
        out_req_next_s   = out_req_r;
        out_data_next_s  = out_data_r;
        out_src_next_s   = out_src_r;
        busy_next_s      = busy_r;
        // The consumer may only change its ack phase while a token is out.
        proto_err_next_s = proto_err_r |
                           ((state_r == IDLE) && (out_ack_s != out_req_r));
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    out_data_next_s = sel_data_s;
                    out_src_next_s  = sel_s;
                    out_req_next_s  = ~out_req_r;
                    busy_next_s     = 1'b1;
                    state_next_s    = SEND;
                end else begin
                    state_next_s    = IDLE;
                end
            end
            SEND: begin
                if (out_ack_s == out_req_r) begin
                    in_ack_next_s[out_src_r] = ~in_ack_r[out_src_r];
                    rr_ptr_next_s            = ptr_inc_s;
                    busy_next_s              = 1'b0;
                    state_next_s             = IDLE;
                end else begin
                    state_next_s             = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            in_ack_r    <= '0;
            out_req_r   <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= '0;
            busy_r      <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rr_ptr_r    <= rr_ptr_next_s;
            in_ack_r    <= in_ack_next_s;
            out_req_r   <= out_req_next_s;
            out_data_r  <= out_data_next_s;
            out_src_r   <= out_src_next_s;
            busy_r      <= busy_next_s;
            proto_err_r <= proto_err_next_s;
        end
    end

    assign bus.in_ack    = in_ack_r;
    assign bus.out_req   = out_req_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;
    assign bus.busy      = busy_r;
    assign bus.proto_err = proto_err_r;

endmodule

// File: doc/rr_handshake_arbiter.md
Name: rr_handshake_arbiter

Overview:
- Synchronous round-robin arbiter sharing one two-phase (transition-signalled) bundled-data output channel between NUM_REQ two-phase requesters.
- Sits in front of a data_copy stage, or any single-input consumer, so several producers can feed it.
- Uses the same req/ack toggle protocol as the existing pipeline stages; each grant forwards exactly one token.

Parameters:
- NUM_REQ, 4, number of requesting channels (1..16).
- WIDTH, 8, data bits per token.
- SRC_W (localparam), max(1, clog2(NUM_REQ)), width of out_src.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_req  in  NUM_REQ  per-requester two-phase request; a toggle means a token is offered.
- in_ack  out  NUM_REQ  per-requester two-phase acknowledge.
- in_data  in  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]; stable while pending.
- out_req  out  1  two-phase request to the consumer.
- out_ack  in  1  two-phase acknowledge from the consumer.
- out_data  out  WIDTH  forwarded token.
- out_src  out  SRC_W  index of the requester whose token is on out_data.
- busy  out  1  high in SEND.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync-free deassert): in_ack=0, out_req=0, out_data=0, out_src=0, busy=0, proto_err=0, rr_ptr=0, state=IDLE.
- pending[i] = in_req_s[i] XOR in_ack[i]. in_req_s is in_req, or its synchronised copy when ARB_SYNC_EN is defined. out_ack_s is treated the same way.
- IDLE state:
  - If any pending, select the first pending index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On that edge: out_data<=in_data[sel], out_src<=sel, out_req<=~out_req, busy<=1, state<=SEND.
  - If no request is pending, hold all outputs.
- SEND state:
  - Wait until out_ack_s==out_req.
  - On that edge: in_ack[sel]<=~in_ack[sel], rr_ptr<=(sel+1) mod NUM_REQ (wraps NUM_REQ-1 -> 0), busy<=0, state<=IDLE.
  - out_data and out_src hold until the next grant.
- Latency (no sync): out_req toggles on the first clk edge after in_req toggles. in_ack toggles on the first edge after out_ack matches. Minimum 2 cycles per token; back-to-back grants are possible in the cycle after returning to IDLE.
- Simultaneous requests: exactly one grant per SEND. Requests arriving during SEND wait and are arbitrated in IDLE with the updated rr_ptr.
  - Fairness: with all NUM_REQ pending, each requester is served once every NUM_REQ grants.
- Requester double-toggle before ack: the XOR cancels it, so it is seen as no request. This is a protocol violation; no flag is raised.
- Consumer errors:
  - out_ack_s!=out_req while in IDLE sets proto_err (sticky until reset). Arbitration continues, and the SEND exit condition is evaluated normally.
- NUM_REQ=1: the arbiter degenerates to a registered two-phase pass-through; out_src is always 0.
- Reset mid-SEND: the token is dropped and all phases return to 0. Producers and consumer must be reset together.

Optional Feature:
- Macro ARB_SYNC_EN.
- Defined: in_req and out_ack each pass through a 2-flop synchroniser, reset to 0, before use. in_data is captured only at grant, which relies on bundled-data stability. Each handshake direction gains 2 cycles, so the minimum per token is 6 cycles.
- Undefined: inputs are used directly and must be synchronous to clk.

Test Plan:
- Reset, then toggle in_req[2] 0->1 with in_data[2]=8'hA5 and the consumer acking 1 cycle after out_req. Required: out_req=1, out_data=A5, out_src=2 on the next edge; in_ack[2]=1 one edge after out_ack=1; rr_ptr=3.
- Toggle all four in_req at once with data 8'h10..8'h13. Required grant order 0,1,2,3 and out_data 10,11,12,13; each in_ack toggles exactly once; final rr_ptr=0.
- Leave rr_ptr=3, then toggle in_req[1] and in_req[3] together. Required grant order 3 then 1, then rr_ptr=2.
- Delay the consumer ack by 10 cycles and toggle in_req[0] meanwhile. Required: busy stays 1 and out_data stays stable for 10 cycles; in_ack[0] does not toggle until its own grant completes.
- In IDLE, toggle out_ack spuriously. Required: proto_err=1 next edge, persisting until rst_n=0. Also assert rst_n mid-SEND: all outputs return to 0 immediately.
- Rebuild with ARB_SYNC_EN and repeat scenario 1. Required: out_req toggles 3 edges after in_req; in_ack toggles 3 edges after out_ack.
